seq_mul_nxn: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 15 +
 rtl/seq_mul_shift_add_step.sv | 24 ++
 rtl/seq_mul_nxn.sv | 118 +++++++++++
 tb/tb_seq_mul_nxn.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Step counter width; a WIDTH of 2 still needs one bit.
    function automatic int cntWidth(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mul_shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// WIDTH+1 accumulator bits, then shift the whole accumulator right by one.
module shift_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic              lsb_i,
    input  logic [WIDTH-1:0]  mcand_i,
    output logic [2*WIDTH:0]  acc_o
);

    logic [WIDTH:0]   upper;
    logic [2*WIDTH:0] sum;

    always_comb begin
        upper = acc_i[2*WIDTH:WIDTH];
        if (lsb_i) begin
            upper = upper + {1'b0, mcand_i};
        end
        sum   = {upper, acc_i[WIDTH-1:0]};
        acc_o = sum >> 1;
    end

endmodule

// File: rtl/seq_mul_nxn.sv
// Sequential WIDTHxWIDTH multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product.
module seq_mul_nxn
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cntWidth(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    state_e             state_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [WIDTH-1:0]   multiplicand_q;
    logic [WIDTH-1:0]   multiplier_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;
    logic [2*WIDTH-1:0] result_d;
    logic [WIDTH-1:0]   magA_d;
    logic [WIDTH-1:0]   magB_d;

    shift_add_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .lsb_i   (multiplier_q[0]),
        .mcand_i (multiplicand_q),
        .acc_o   (acc_d)
    );

`ifdef SEQ_MUL_SIGNED_EN
    logic sign_q;

    // The core only ever sees magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
    always_comb begin
        magA_d   = a[WIDTH-1] ? -a : a;
        magB_d   = b[WIDTH-1] ? -b : b;
        result_d = sign_q ? -acc_d[2*WIDTH-1:0] : acc_d[2*WIDTH-1:0];
    end
`else
    always_comb begin
        magA_d   = a;
        magB_d   = b;
        result_d = acc_d[2*WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            count_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            product_q      <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        multiplicand_q <= magA_d;
                        multiplier_q   <= magB_d;
                        acc_q          <= '0;
                        count_q        <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
                        sign_q         <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    acc_q        <= acc_d;
                    multiplier_q <= multiplier_q >> 1;
                    // Counter holds at WIDTH-1 on the final step so it never wraps.
                    if (count_q == CW'(WIDTH - 1)) begin
                        product_q <= result_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mul_nxn.sv
// Directed and random checks of seq_mul_nxn at WIDTH=4 and WIDTH=8; honours SEQ_MUL_SIGNED_EN.
module tb_seq_mul_nxn;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    seq_mul_nxn #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    seq_mul_nxn #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [15:0] p;
        p = $signed(x) * $signed(y);
        return p;
`else
        return {8'h00, x} * {8'h00, y};
`endif
    endfunction

    // Entered and left at one time unit after a rising edge.
    task automatic applyStimulus4(input string tag, input logic [3:0] aVal, input logic [3:0] bVal,
                                  input logic [7:0] expProd);
        int edges;
        edges  = 0;
        a4     = aVal;
        b4     = bVal;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4     = ~aVal;
        b4     = ~bVal;
        checkOutput({tag, "_busy"}, 32'(busy4), 32'd1);
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done4 && edges < 20);
        checkOutput({tag, "_lat"}, edges, 32'd4);
        checkOutput({tag, "_prod"}, 32'(product4), 32'(expProd));
        @(posedge clk); #1;
        checkOutput({tag, "_idle"}, 32'(busy4), 32'd0);
        checkOutput({tag, "_donelo"}, 32'(done4), 32'd0);
    endtask

    task automatic applyStimulus8(input string tag, input logic [7:0] aVal, input logic [7:0] bVal,
                                  input logic [15:0] expProd, input bit full);
        int edges;
        edges  = 0;
        a8     = aVal;
        b8     = bVal;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8     = $urandom;
        b8     = $urandom;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done8 && edges < 30);
        if (full || edges != 8) begin
            checkOutput({tag, "_lat"}, edges, 32'd8);
        end
        checkOutput({tag, "_prod"}, 32'(product8), 32'(expProd));
        @(posedge clk); #1;
        if (full) begin
            checkOutput({tag, "_idle"}, 32'(busy8), 32'd0);
        end
    endtask

    initial begin
        int edges;
        int doneSeen;
        logic [7:0] ra;
        logic [7:0] rb;

        #3;
        checkOutput("rst_busy4", 32'(busy4), 32'd0);
        checkOutput("rst_done4", 32'(done4), 32'd0);
        checkOutput("rst_prod4", 32'(product4), 32'd0);
        checkOutput("rst_prod8", 32'(product8), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_busy4", 32'(busy4), 32'd0);

        applyStimulus4("u3x3", 4'd3, 4'd3, 8'd9);
`ifdef SEQ_MUL_SIGNED_EN
        applyStimulus4("s_m3x5", 4'hD, 4'h5, 8'hF1);
        applyStimulus4("s_m8xm8", 4'h8, 4'h8, 8'h40);
        applyStimulus4("s_m8x7", 4'h8, 4'h7, 8'hC8);
`else
        applyStimulus4("u15x15", 4'hF, 4'hF, 8'hE1);
        applyStimulus4("u10x0", 4'hA, 4'h0, 8'h00);
`endif

        // Start held high: second operation must be accepted exactly at edge WIDTH+2.
        a4     = 4'd2;
        b4     = 4'd5;
        start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd7;
        b4 = 4'd7;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done4 && edges < 20);
        checkOutput("hold_lat1", edges, 32'd4);
        checkOutput("hold_prod1", 32'(product4), 32'd10);
        @(posedge clk); #1;
        checkOutput("hold_gap", 32'(busy4), 32'd0);
        @(posedge clk); #1;
        checkOutput("hold_accept", 32'(busy4), 32'd1);
        start4 = 1'b0;
        edges  = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done4 && edges < 20);
        checkOutput("hold_lat2", edges, 32'd4);
        checkOutput("hold_prod2", 32'(product4), 32'd49);
        @(posedge clk); #1;

        // Abort during RUN with count=2.
        a4     = 4'd5;
        b4     = 4'd6;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy4), 32'd0);
        checkOutput("abort_done", 32'(done4), 32'd0);
        checkOutput("abort_prod", 32'(product4), 32'd0);
        #1;
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) doneSeen++;
        end
        checkOutput("abort_nodone", doneSeen, 32'd0);
        applyStimulus4("after_rst", 4'd3, 4'd4, 8'd12);

`ifdef SEQ_MUL_SIGNED_EN
        applyStimulus8("w8_m1xm1", 8'hFF, 8'hFF, 16'h0001, 1'b1);
        applyStimulus8("w8_m128x127", 8'h80, 8'h7F, 16'hC080, 1'b1);
`else
        applyStimulus8("w8_255x255", 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        applyStimulus8("w8_128x2", 8'h80, 8'h02, 16'h0100, 1'b1);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus8("rand", ra, rb, model8(ra, rb), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
